// File: rtl/iob_2p_assim_fifo_pkg.sv
// Shared width/ratio helpers for the asymmetric-width FIFO and its storage.
package iob_2p_assim_fifo_pkg;

   localparam int DEF_W_DATA_W = 16;
   localparam int DEF_W_ADDR_W = 6;
   localparam int DEF_R_DATA_W = 8;
   localparam int DEF_R_ADDR_W = 7;

   function automatic int f_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int f_min(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int f_clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/iob_2p_assim_fifo_if.sv
// Write/read handshake bundle of the asymmetric FIFO; level is in narrow-word units.
interface iob_2p_assim_fifo_if
   import iob_2p_assim_fifo_pkg::*;
#(
   parameter int W_DATA_W = DEF_W_DATA_W,
   parameter int W_ADDR_W = DEF_W_ADDR_W,
   parameter int R_DATA_W = DEF_R_DATA_W,
   parameter int R_ADDR_W = DEF_R_ADDR_W
);
   localparam int LVL_W = f_max(W_ADDR_W, R_ADDR_W) + 1;

   logic                w_en;
   logic [W_DATA_W-1:0] w_data;
   logic                w_full;
   logic                w_ovf;
   logic                r_en;
   logic [R_DATA_W-1:0] r_data;
   logic                r_valid;
   logic                r_empty;
   logic                r_udf;
   logic [LVL_W-1:0]    level;

   modport master (
      output w_en, w_data, r_en,
      input  w_full, w_ovf, r_data, r_valid, r_empty, r_udf, level
   );

   modport slave (
      input  w_en, w_data, r_en,
      output w_full, w_ovf, r_data, r_valid, r_empty, r_udf, level
   );
endinterface

// File: rtl/iob_2p_assim_fifo_mem.sv
// Asymmetric two-port RAM built from narrow banks; wide side touches every bank,
// narrow side picks one bank with the low address bits (little-endian sub-words).
module iob_2p_assim_mem
   import iob_2p_assim_fifo_pkg::*;
#(
   parameter int W_DATA_W = DEF_W_DATA_W,
   parameter int W_ADDR_W = DEF_W_ADDR_W,
   parameter int R_DATA_W = DEF_R_DATA_W,
   parameter int R_ADDR_W = DEF_R_ADDR_W
) (
   input  logic                clk,
   input  logic                i_w_en,
   input  logic [W_ADDR_W-1:0] i_w_addr,
   input  logic [W_DATA_W-1:0] i_w_data,
   input  logic                i_r_en,
   input  logic [R_ADDR_W-1:0] i_r_addr,
   output logic [R_DATA_W-1:0] o_r_data
);
   localparam int NW    = f_min(W_DATA_W, R_DATA_W);
   localparam int RATIO = f_max(W_DATA_W, R_DATA_W) / NW;
   localparam int SEL_W = f_clog2(RATIO);
   localparam int BA_W  = f_min(W_ADDR_W, R_ADDR_W);
   localparam int DEPTH = 2 ** BA_W;

   logic [NW-1:0] w_bank_q [RATIO];

   for (genvar gi = 0; gi < RATIO; gi++) begin : g_bank
      logic [NW-1:0]   r_mem [DEPTH];
      logic [NW-1:0]   r_q;
      logic            w_we;
      logic [BA_W-1:0] w_waddr;
      logic [BA_W-1:0] w_raddr;
      logic [NW-1:0]   w_wdata;

      if (W_DATA_W >= R_DATA_W) begin : g_wwide
         assign w_we    = i_w_en;
         assign w_waddr = i_w_addr;
         assign w_wdata = i_w_data[gi*NW +: NW];
      end else begin : g_wnarrow
         assign w_we    = i_w_en && (i_w_addr[SEL_W-1:0] == SEL_W'(gi));
         assign w_waddr = i_w_addr[W_ADDR_W-1:SEL_W];
         assign w_wdata = i_w_data;
      end

      if (R_DATA_W >= W_DATA_W) begin : g_rwide_addr
         assign w_raddr = i_r_addr;
      end else begin : g_rnarrow_addr
         assign w_raddr = i_r_addr[R_ADDR_W-1:SEL_W];
      end

      // Read register only moves on a read, so data holds between reads.
      always_ff @(posedge clk) begin
         if (w_we) r_mem[w_waddr] <= w_wdata;
         if (i_r_en) r_q <= r_mem[w_raddr];
      end

      assign w_bank_q[gi] = r_q;
   end

   if (R_DATA_W >= W_DATA_W) begin : g_rwide
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_cat
         assign o_r_data[gi*NW +: NW] = w_bank_q[gi];
      end
   end else begin : g_rnarrow
      logic [SEL_W-1:0] r_sel;
      always_ff @(posedge clk) begin
         if (i_r_en) r_sel <= i_r_addr[SEL_W-1:0];
      end
      assign o_r_data = w_bank_q[r_sel];
   end

endmodule

// File: rtl/iob_2p_assim_fifo.sv
// Pointer/level controller of the asymmetric-width FIFO; storage lives in iob_2p_assim_mem.
module iob_2p_assim_fifo
   import iob_2p_assim_fifo_pkg::*;
#(
   parameter int W_DATA_W = DEF_W_DATA_W,
   parameter int W_ADDR_W = DEF_W_ADDR_W,
   parameter int R_DATA_W = DEF_R_DATA_W,
   parameter int R_ADDR_W = DEF_R_ADDR_W
) (
   input logic                  clk,
   input logic                  rst,
   iob_2p_assim_fifo_if.slave   bus
);
   localparam int N_ADDR_W = f_max(W_ADDR_W, R_ADDR_W);
   localparam int NARROW   = f_min(W_DATA_W, R_DATA_W);
   localparam int WG       = W_DATA_W / NARROW;
   localparam int RG       = R_DATA_W / NARROW;
   localparam int CAP      = 2 ** N_ADDR_W;
   localparam int LVL_W    = N_ADDR_W + 1;

   logic [W_ADDR_W-1:0] r_wptr;
   logic [R_ADDR_W-1:0] r_rptr;
   logic [LVL_W-1:0]    r_level;
   logic [LVL_W-1:0]    w_level_next;
   logic                r_rvalid;
   logic                r_wovf;
   logic                r_rudf;
   logic                w_full;
   logic                w_empty;
   logic                w_wacc;
   logic                w_racc;

   assign w_full  = r_level > LVL_W'(CAP - WG);
   assign w_empty = r_level < LVL_W'(RG);
   assign w_wacc  = bus.w_en && !w_full && !rst;
   assign w_racc  = bus.r_en && !w_empty && !rst;

   always_comb begin
      w_level_next = r_level;
      if (w_wacc) w_level_next = w_level_next + LVL_W'(WG);
      if (w_racc) w_level_next = w_level_next - LVL_W'(RG);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_level  <= '0;
         r_rvalid <= 1'b0;
         r_wovf   <= 1'b0;
         r_rudf   <= 1'b0;
      end else begin
         if (w_wacc) r_wptr <= r_wptr + 1'b1;
         if (w_racc) r_rptr <= r_rptr + 1'b1;
         r_level  <= w_level_next;
         r_rvalid <= w_racc;
         r_wovf   <= bus.w_en && w_full;
         r_rudf   <= bus.r_en && w_empty;
      end
   end

   iob_2p_assim_mem #(
      .W_DATA_W (W_DATA_W),
      .W_ADDR_W (W_ADDR_W),
      .R_DATA_W (R_DATA_W),
      .R_ADDR_W (R_ADDR_W)
   ) u_mem (
      .clk      (clk),
      .i_w_en   (w_wacc),
      .i_w_addr (r_wptr),
      .i_w_data (bus.w_data),
      .i_r_en   (w_racc),
      .i_r_addr (r_rptr),
      .o_r_data (bus.r_data)
   );

   assign bus.w_full  = w_full;
   assign bus.w_ovf   = r_wovf;
   assign bus.r_valid = r_rvalid;
   assign bus.r_empty = w_empty;
   assign bus.r_udf   = r_rudf;
   assign bus.level   = r_level;

endmodule

// File: tb/tb_iob_2p_assim_fifo.sv
// Randomized bench for the 16-bit-write / 8-bit-read FIFO against a byte-queue model.
module tb_iob_2p_assim_fifo;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   iob_2p_assim_fifo_if bus ();

   iob_2p_assim_fifo dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] model_q[$];
   logic [7:0] last_rd;
   bit         have_rd = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; the model is a byte queue whose size is the level.
   task automatic step(input bit rs, input bit we, input logic [15:0] wd, input bit re);
      int         lvl;
      bit         wacc;
      bit         racc;
      logic [7:0] exp_rd;
      exp_rd = 8'h00;
      @(negedge clk);
      rst         = rs;
      bus.w_en    = we;
      bus.w_data  = wd;
      bus.r_en    = re;
      lvl  = model_q.size();
      wacc = !rs && we && (lvl + 2 <= 128);
      racc = !rs && re && (lvl >= 1);
      if (rs) begin
         model_q.delete();
         have_rd = 0;
      end else begin
         if (racc) exp_rd = model_q.pop_front();
         if (wacc) begin
            model_q.push_back(wd[7:0]);
            model_q.push_back(wd[15:8]);
         end
      end
      @(posedge clk);
      #1;
      $display("t=%0t rst=%0b w=%0b/%h r=%0b lvl=%0d rv=%0b rd=%h", $time, rs, we, wd, re,
               bus.level, bus.r_valid, bus.r_data);
      chk("level",   32'(bus.level),   32'(model_q.size()));
      chk("w_full",  32'(bus.w_full),  32'(model_q.size() > 126));
      chk("r_empty", 32'(bus.r_empty), 32'(model_q.size() < 1));
      chk("r_valid", 32'(bus.r_valid), 32'(racc));
      chk("w_ovf",   32'(bus.w_ovf),   32'(!rs && we && !wacc));
      chk("r_udf",   32'(bus.r_udf),   32'(!rs && re && !racc));
      if (racc) begin
         chk("r_data", 32'(bus.r_data), 32'(exp_rd));
         last_rd = exp_rd;
         have_rd = 1;
      end else if (have_rd) begin
         chk("r_hold", 32'(bus.r_data), 32'(last_rd));
      end
   endtask

   initial begin
      rst        = 1'b1;
      bus.w_en   = 1'b0;
      bus.w_data = '0;
      bus.r_en   = 1'b0;

      step(1, 0, 16'h0, 0);
      chk("rst_level", 32'(bus.level), 32'd0);

      step(0, 1, 16'hA1B2, 0);
      step(0, 0, 16'h0, 1);
      chk("order0", 32'(bus.r_data), 32'h0B2);
      step(0, 0, 16'h0, 1);
      chk("order1", 32'(bus.r_data), 32'h0A1);
      step(0, 0, 16'h0, 0);

      for (int i = 0; i < 64; i++) step(0, 1, 16'($urandom), 0);
      chk("full_level", 32'(bus.level), 32'd128);
      step(0, 1, 16'hFFFF, 0);
      chk("ovf_pulse", 32'(bus.w_ovf), 32'd1);
      for (int i = 0; i < 128; i++) step(0, 0, 16'h0, 1);
      step(0, 0, 16'h0, 1);
      chk("udf_pulse", 32'(bus.r_udf), 32'd1);
      step(0, 0, 16'h0, 0);

      for (int i = 0; i < 5; i++) step(0, 1, 16'($urandom), 0);
      step(0, 1, 16'($urandom), 1);
      chk("simul_level", 32'(bus.level), 32'd11);
      while (model_q.size() > 0) step(0, 0, 16'h0, 1);

      for (int i = 0; i < 300; i++)
         step(0, $urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 60);

      step(1, 0, 16'h0, 0);
      for (int i = 0; i < 25; i++) step(0, 1, 16'($urandom), 0);
      chk("mid_level", 32'(bus.level), 32'd50);
      step(0, 0, 16'h0, 1);
      step(1, 1, 16'h1234, 1);
      chk("mrst_level", 32'(bus.level), 32'd0);
      chk("mrst_valid", 32'(bus.r_valid), 32'd0);
      step(0, 1, 16'h5A3C, 0);
      step(0, 0, 16'h0, 1);
      chk("post_rst_rd", 32'(bus.r_data), 32'h03C);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/iob_2p_assim_fifo.md
IOB_2P_ASSIM_FIFO -- requirements
Module: iob_2p_assim_fifo

Interface
REQ-001 SHALL have parameter W_DATA_W, default 16, meaning write-port word width.
REQ-002 SHALL have parameter W_ADDR_W, default 6, meaning write-side address width.
REQ-003 SHALL have parameter R_DATA_W, default 8, meaning read-port word width.
REQ-004 SHALL have parameter R_ADDR_W, default 7, meaning read-side address width; W_DATA_W*2^W_ADDR_W == R_DATA_W*2^R_ADDR_W, and the width ratio is a power of 2.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port w_en  input  1  write request.
REQ-008 SHALL have port w_data  input  W_DATA_W  write data.
REQ-009 SHALL have port w_full  output  1  no room for one write word.
REQ-010 SHALL have port w_ovf  output  1  one-cycle pulse: write rejected.
REQ-011 SHALL have port r_en  input  1  read request.
REQ-012 SHALL have port r_data  output  R_DATA_W  read data.
REQ-013 SHALL have port r_valid  output  1  r_data valid this cycle.
REQ-014 SHALL have port r_empty  output  1  less than one read word stored.
REQ-015 SHALL have port r_udf  output  1  one-cycle pulse: read rejected.
REQ-016 SHALL have port level  output  N_ADDR_W+1  fill level in narrow-word units; N_ADDR_W = max(W_ADDR_W,R_ADDR_W).

Function
REQ-017 SHALL define units: narrow width = min(W_DATA_W,R_DATA_W); WG = W_DATA_W/narrow; RG = R_DATA_W/narrow; CAP = 2^N_ADDR_W.
REQ-018 SHALL keep registered write pointer (W_ADDR_W bits) and read pointer (R_ADDR_W bits), each incrementing by 1 per accepted access, wrapping modulo 2^width.
REQ-019 SHALL derive w_full = (level > CAP-WG) and r_empty = (level < RG) combinationally from the level register.
REQ-020 SHALL accept a write when w_en=1 and w_full=0: memory write issued same cycle, level += WG next cycle.
REQ-021 SHALL reject w_en=1 while w_full=1: no memory write, pointer/level unchanged, w_ovf=1 next cycle for one cycle.
REQ-022 SHALL accept a read when r_en=1 and r_empty=0: memory read issued same cycle, level -= RG next cycle, r_valid=1 and r_data valid exactly one cycle later.
REQ-023 SHALL reject r_en=1 while r_empty=1: no pointer/level change, r_valid stays 0, r_udf=1 next cycle for one cycle.
REQ-024 SHALL on simultaneous accepted write and read update level by +WG-RG in one step; acceptance of each is judged on pre-update flags.
REQ-025 SHALL order sub-words little-endian: the first narrow word read from a wide write is w_data[narrow-1:0]; wide reads assemble narrow writes LSB first.
REQ-026 SHALL sustain one write and one read per cycle back-to-back.
REQ-027 SHALL hold r_data stable when r_valid=0 after the last read.

Reset
REQ-028 SHALL on rst=1 at a clock edge clear both pointers and level to 0, r_valid, w_ovf, r_udf to 0; hence r_empty=1, w_full=0 next cycle.
REQ-029 SHALL give rst priority over w_en/r_en in the same cycle; a read accepted in the cycle before rst yields no r_valid after reset.
REQ-030 SHALL not reset memory contents; r_data is undefined until first r_valid.

Structure
REQ-031 SHALL place N_ADDR_W, WG, RG, CAP derivation helpers (clog2, min/max) in a shared package.
REQ-032 SHALL instantiate the existing iob_2p_assim_mem as its single sub-module for storage; this block is the pointer/level controller only.

Verification (defaults: WG=2, RG=1, CAP=128)
REQ-033 SHALL check reset: after rst, level=0, r_empty=1, w_full=0, r_valid=0.
REQ-034 SHALL check ordering: write 0xA1B2, read twice -> r_data 0xB2 then 0xA1, each r_valid one cycle after r_en, level 2->1->0.
REQ-035 SHALL check full: 64 writes -> level=128, w_full=1; 65th write -> w_ovf pulse, level stays 128; read on empty -> r_udf pulse.
REQ-036 SHALL check simultaneous: at level 10, w_en=r_en=1 -> level 11.
REQ-037 SHALL check wrap: 300 random interleaved writes/reads, read stream equals scoreboard byte stream.
REQ-038 SHALL check mid-operation reset: at level 50 with r_en=1, rst=1 -> next cycle level=0, r_empty=1, r_valid=0.
